// File: rtl/divsqrt_pkg.sv
// Shared types and helpers for the iterative mantissa divide/square-root core.
// Provides the operation and FSM state encodings and the result-width helper
// qw(), so every file derives the same result width from WIDTH/GUARD.
package divsqrt_pkg;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_SQRT = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result width and iteration count: mantissa + guard bits + one integer bit.
  function automatic int qw(input int width, input int guard);
    return width + guard + 1;
  endfunction

endpackage

// File: rtl/mant_divsqrt_iter_if.sv
// Operand/result bundle between the FP div/sqrt wrapper and the mantissa core.
// Request side: in_valid/in_ready, op, odd_exp, a, b.
// Response side: out_valid/out_ready, q, sticky, dz. master = wrapper, slave = core.
interface mant_divsqrt_iter_if
  import divsqrt_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int GUARD = 3
) ();
  localparam int QW = qw(WIDTH, GUARD);

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic             odd_exp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    q;
  logic             sticky;
  logic             dz;

  modport master (
    output in_valid, op, odd_exp, a, b, out_ready,
    input  in_ready, out_valid, q, sticky, dz
  );

  modport slave (
    input  in_valid, op, odd_exp, a, b, out_ready,
    output in_ready, out_valid, q, sticky, dz
  );
endinterface

// File: rtl/divsqrt_step.sv
// One radix-2 restoring iteration, shared by divide and square root (pure comb).
// Ports: i_op selects the recurrence, i_rem is the stored remainder, i_part is
// the divisor (div) or partial root (sqrt), i_rad the next two radicand bits;
// o_rem is the remainder to store, o_qbit the result bit produced.
module divsqrt_step
  import divsqrt_pkg::*;
#(
  parameter int QW = 28
) (
  input  op_e            i_op,
  input  logic [QW+1:0]  i_rem,
  input  logic [QW-1:0]  i_part,
  input  logic [1:0]     i_rad,
  output logic [QW+1:0]  o_rem,
  output logic           o_qbit
);
  localparam int RW = QW + 2;

  logic [RW-1:0] w_cmp;
  logic [RW-1:0] w_sub;
  logic [RW-1:0] w_res;
  logic [RW:0]   w_diff;

  always_comb begin
    if (i_op == OP_SQRT) begin
      // Bring down the next radicand pair; trial subtrahend is 4*root + 1.
      // The stored sqrt remainder is at most 2*root < 2^QW, so the dropped
      // top two bits are always zero for normalised inputs.
      w_cmp = {i_rem[RW-3:0], i_rad};
      w_sub = {i_part, 2'b01};
    end else begin
      // Div keeps the remainder pre-doubled, so compare directly against b.
      w_cmp = i_rem;
      w_sub = {2'b00, i_part};
    end
    w_diff = {1'b0, w_cmp} - {1'b0, w_sub};
    o_qbit = ~w_diff[RW];
    w_res  = o_qbit ? w_diff[RW-1:0] : w_cmp;
    o_rem  = (i_op == OP_SQRT) ? w_res : {w_res[RW-2:0], 1'b0};
  end
endmodule

// File: rtl/mant_divsqrt_iter.sv
// Radix-2 iterative mantissa divide / square-root core, one operation in flight.
// Latency: QW edges from accept to out_valid (divide-by-zero: DONE on the accept
// edge). With DIVSQRT_EARLY_EXIT_EN defined, finishes as soon as the remainder
// and the unconsumed radicand are zero (1..QW edges).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, reset (sync, active-low), flush (sync abort), io (slave modport).
module mant_divsqrt_iter
  import divsqrt_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int GUARD = 3
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  mant_divsqrt_iter_if.slave io
);
  localparam int QW = qw(WIDTH, GUARD);
  localparam int RW = QW + 2;
  localparam int XW = 2 * QW;
  localparam int CW = $clog2(QW);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]    r_rem;
  logic [QW-1:0]    r_q;
  logic [XW-1:0]    r_x;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  logic             w_accept;
  logic             w_bz;
  logic             w_last;
  logic             w_early;
  logic [QW-1:0]    w_part;
  logic [RW-1:0]    w_step_rem;
  logic             w_qbit;
  logic [QW-1:0]    w_q_nxt;
  logic [XW-1:0]    w_x_nxt;

  assign w_accept = io.in_valid && reset && (r_state == IDLE);
  assign w_bz     = (io.b == '0);
  assign w_last   = (r_cnt == '0);
  assign w_part   = (r_op == OP_SQRT) ? r_q : QW'(r_b);
  assign w_q_nxt  = {r_q[QW-2:0], w_qbit};
  assign w_x_nxt  = r_x << 2;

  divsqrt_step #(.QW(QW)) u_step (
    .i_op   (r_op),
    .i_rem  (r_rem),
    .i_part (w_part),
    .i_rad  (r_x[XW-1:XW-2]),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

`ifdef DIVSQRT_EARLY_EXIT_EN
  // Zero remainder with no radicand bits left means every later bit is 0.
  assign w_early = (w_step_rem == '0) && (w_x_nxt == '0);
`else
  assign w_early = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = ((io.op == OP_DIV) && w_bz) ? DONE : ITER;
      ITER: if (w_last || w_early) w_state_nxt = DONE;
      DONE: if (io.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // Handshake outputs; in_ready is held low for the whole reset assertion
  always_comb begin
    io.in_ready  = reset && (r_state == IDLE);
    io.out_valid = (r_state == DONE);
  end

  assign io.q      = r_q;
  assign io.sticky = |r_rem;
  assign io.dz     = r_dz;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op  <= OP_DIV;
      r_b   <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_x   <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
    end else if (flush) begin
      r_dz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= io.op;
            r_b   <= io.b;
            r_cnt <= CW'(QW - 1);
            r_dz  <= 1'b0;
            r_q   <= '0;
            if (io.op == OP_DIV) begin
              r_x <= '0;
              if (w_bz) begin
                r_q   <= '1;
                r_rem <= '0;
                r_dz  <= 1'b1;
              end else begin
                r_rem <= RW'(io.a);
              end
            end else begin
              // Radicand a * 2^(2QW-WIDTH-odd_exp) laid out in a 2*QW-bit field.
              r_rem <= '0;
              r_x   <= io.odd_exp ? {1'b0, io.a, {(XW-WIDTH-1){1'b0}}}
                                  : {io.a, {(XW-WIDTH){1'b0}}};
            end
          end
        end
        ITER: begin
          r_rem <= w_step_rem;
          r_x   <= w_x_nxt;
          r_cnt <= r_cnt - CW'(1);
          r_q   <= w_q_nxt;
`ifdef DIVSQRT_EARLY_EXIT_EN
          // Align the bits produced so far to their final weight.
          if (w_early) r_q <= w_q_nxt << r_cnt;
`endif
        end
        DONE: begin
          if (io.out_ready) r_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mant_divsqrt_iter.sv
// Directed self-checking bench for mant_divsqrt_iter (WIDTH=24 and WIDTH=53).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected latencies depend on whether DIVSQRT_EARLY_EXIT_EN is defined.
module tb_mant_divsqrt_iter;
  import divsqrt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush24;
  logic flush53;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   hits;

`ifdef DIVSQRT_EARLY_EXIT_EN
  localparam int LAT_ONE  = 1;
  localparam int LAT_3_2  = 2;
  localparam int LAT_SQ1  = 1;
  localparam int LAT_53   = 1;
`else
  localparam int LAT_ONE  = 28;
  localparam int LAT_3_2  = 28;
  localparam int LAT_SQ1  = 28;
  localparam int LAT_53   = 57;
`endif

  always #5 clk = ~clk;

  mant_divsqrt_iter_if #(.WIDTH(24), .GUARD(3)) if24 ();
  mant_divsqrt_iter_if #(.WIDTH(53), .GUARD(3)) if53 ();

  mant_divsqrt_iter #(.WIDTH(24), .GUARD(3)) dut24 (
    .clk   (clk),
    .reset (reset),
    .flush (flush24),
    .io    (if24)
  );

  mant_divsqrt_iter #(.WIDTH(53), .GUARD(3)) dut53 (
    .clk   (clk),
    .reset (reset),
    .flush (flush53),
    .io    (if53)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start24(input op_e op, input logic odd, input logic [23:0] a,
                         input logic [23:0] b);
    @(negedge clk);
    if24.op       = op;
    if24.odd_exp  = odd;
    if24.a        = a;
    if24.b        = b;
    if24.in_valid = 1'b1;
    @(negedge clk);
    if24.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded at 200.
  task automatic wait24(output int cnt);
    cnt = 0;
    while (!if24.out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run24(input string tag, input op_e op, input logic odd,
                       input logic [23:0] a, input logic [23:0] b,
                       input logic [27:0] eq, input logic es, input logic ed,
                       input int el);
    int lat;
    start24(op, odd, a, b);
    wait24(lat);
    chk($sformatf("%s_lat", tag), 64'(lat), 64'(el));
    chk($sformatf("%s_q", tag), 64'(if24.q), 64'(eq));
    chk($sformatf("%s_sticky", tag), 64'(if24.sticky), 64'(es));
    chk($sformatf("%s_dz", tag), 64'(if24.dz), 64'(ed));
    @(negedge clk);
    // out_ready is high: handshake happened, core back in IDLE, dz cleared
    chk($sformatf("%s_release", tag), {61'd0, if24.out_valid, if24.in_ready, if24.dz},
        64'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    flush24 = 1'b0;
    flush53 = 1'b0;
    if24.in_valid = 1'b0; if24.op = OP_DIV; if24.odd_exp = 1'b0;
    if24.a = '0; if24.b = '0; if24.out_ready = 1'b1;
    if53.in_valid = 1'b0; if53.op = OP_DIV; if53.odd_exp = 1'b0;
    if53.a = '0; if53.b = '0; if53.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(if24.in_ready), 64'd0);
    chk("rst_out_valid", 64'(if24.out_valid), 64'd0);
    chk("rst_q", 64'(if24.q), 64'd0);
    chk("rst_sticky_dz", {62'd0, if24.sticky, if24.dz}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(if24.in_ready), 64'd1);

    // Main function
    run24("div_1_1",   OP_DIV,  1'b0, 24'h800000, 24'h800000, 28'h8000000, 1'b0, 1'b0, LAT_ONE);
    run24("div_1_1p5", OP_DIV,  1'b0, 24'h800000, 24'hC00000, 28'h5555555, 1'b1, 1'b0, 28);
    run24("div_1p5_1", OP_DIV,  1'b0, 24'hC00000, 24'h800000, 28'hC000000, 1'b0, 1'b0, LAT_3_2);
    run24("sqrt_even", OP_SQRT, 1'b0, 24'h800000, 24'h000000, 28'hB504F33, 1'b1, 1'b0, 28);
    run24("sqrt_odd",  OP_SQRT, 1'b1, 24'h800000, 24'h123456, 28'h8000000, 1'b0, 1'b0, LAT_SQ1);
    run24("div_bz",    OP_DIV,  1'b0, 24'h800000, 24'h000000, 28'hFFFFFFF, 1'b0, 1'b1, 0);

    // Output backpressure: result and handshake state hold while out_ready=0
    if24.out_ready = 1'b0;
    start24(OP_DIV, 1'b0, 24'h800000, 24'hC00000);
    wait24(n);
    chk("hold_lat", 64'(n), 64'd28);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_%0d", i),
          {33'd0, if24.out_valid, if24.in_ready, if24.sticky, if24.q},
          {33'd0, 1'b1, 1'b0, 1'b1, 28'h5555555});
      @(negedge clk);
    end
    if24.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {62'd0, if24.out_valid, if24.in_ready}, 64'b01);

    // Flush during ITER: back to IDLE next edge, result never appears
    start24(OP_DIV, 1'b0, 24'h800000, 24'hC00000);
    repeat (5) @(negedge clk);
    flush24 = 1'b1;
    @(negedge clk);
    flush24 = 1'b0;
    chk("flush_iter", {61'd0, if24.out_valid, if24.in_ready, if24.dz}, 64'b010);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if24.out_valid) hits++;
    end
    chk("flush_no_valid", 64'(hits), 64'd0);

    // Flush in DONE beats the pending result and clears dz
    if24.out_ready = 1'b0;
    start24(OP_DIV, 1'b0, 24'h800000, 24'h000000);
    chk("bz_done", {62'd0, if24.out_valid, if24.dz}, 64'b11);
    flush24 = 1'b1;
    @(negedge clk);
    flush24 = 1'b0;
    if24.out_ready = 1'b1;
    chk("flush_done", {61'd0, if24.out_valid, if24.in_ready, if24.dz}, 64'b010);

    // Reset mid-ITER clears every output on the next edge
    start24(OP_SQRT, 1'b0, 24'h800000, 24'h000000);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_iter", {29'd0, if24.out_valid, if24.in_ready, if24.sticky, if24.dz, if24.q},
        64'd0);
    reset = 1'b1;
    #1;
    chk("rst_iter_rel", 64'(if24.in_ready), 64'd1);
    run24("post_rst", OP_DIV, 1'b0, 24'hC00000, 24'h800000, 28'hC000000, 1'b0, 1'b0, LAT_3_2);

    // Double-precision width: 1.0 / 1.0
    @(negedge clk);
    if53.op = OP_DIV;
    if53.a = 53'h10_0000_0000_0000;
    if53.b = 53'h10_0000_0000_0000;
    if53.in_valid = 1'b1;
    @(negedge clk);
    if53.in_valid = 1'b0;
    n = 0;
    while (!if53.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("w53_lat", 64'(n), 64'(LAT_53));
    chk("w53_q", 64'(if53.q), 64'h0100_0000_0000_0000);
    chk("w53_sticky_dz", {62'd0, if53.sticky, if53.dz}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
